// File: rtl/mips_pkg.sv
// Shared MIPS54 definitions for the multiply/divide unit: op encodings,
// FSM state encoding and Hi/Lo write-enable codes.
package mips_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    typedef enum logic [1:0] {
        HLW_NONE = 2'b00,
        HLW_LO   = 2'b01,
        HLW_HI   = 2'b10,
        HLW_BOTH = 2'b11
    } hlw_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath on unsigned magnitudes:
// right-shift add for multiply, shift and trial-subtract for divide.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] divisor,
    input  logic             in_bit,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;

    always_comb begin
        sum     = {1'b0, hi} + (in_bit ? {1'b0, mcand} : '0);
        shifted = {hi, in_bit};
        hi_nxt  = '0;
        lo_nxt  = '0;
        if (div_mode) begin
            // Partial remainder stays below the divisor, so the W-bit difference never wraps.
            if (shifted >= {1'b0, divisor}) begin
                hi_nxt = shifted[WIDTH-1:0] - divisor;
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit; sole writer of the Hi/Lo pair.
// Mul/div take 33 busy cycles (32 iterations + sign fix), MTxx goes straight to DONE.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic [1:0]       HL_W
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mdu_state_e       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] hi_acc;
    logic [WIDTH-1:0] lo_acc;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic             step_bit;
    logic             sgn_op;

    // Divide consumes dividend bits MSB first; multiply consumes multiplier bits LSB first.
    always_comb begin
        step_bit = is_div ? mag_a[CNT_LAST - cnt] : mag_b[cnt];
        sgn_op   = (op == MDU_MULT) || (op == MDU_DIV);
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .hi       (hi_acc),
        .lo       (lo_acc),
        .mcand    (mag_a),
        .divisor  (mag_b),
        .in_bit   (step_bit),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            a_raw  <= '0;
            hi_acc <= '0;
            lo_acc <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Hi_out <= '0;
            Lo_out <= '0;
            HL_W   <= HLW_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                // Sign flags stay clear for unsigned ops, so FIX never negates them.
                                neg_a  <= sgn_op & a[WIDTH-1];
                                neg_b  <= sgn_op & b[WIDTH-1];
                                mag_a  <= (sgn_op && a[WIDTH-1]) ? -a : a;
                                mag_b  <= (sgn_op && b[WIDTH-1]) ? -b : b;
                                a_raw  <= a;
                                is_div <= (op == MDU_DIV) || (op == MDU_DIVU);
                                hi_acc <= '0;
                                lo_acc <= '0;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= ST_RUN;
                            end
                            MDU_MTHI: begin
                                Hi_out <= a;
                                HL_W   <= HLW_HI;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            MDU_MTLO: begin
                                Lo_out <= a;
                                HL_W   <= HLW_LO;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    hi_acc <= hi_nxt;
                    lo_acc <= lo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (is_div && mag_b == '0) begin
                        Lo_out <= '1;
                        Hi_out <= a_raw;
                    end else if (is_div) begin
                        Lo_out <= (neg_a ^ neg_b) ? -lo_acc : lo_acc;
                        Hi_out <= neg_a ? -hi_acc : hi_acc;
                    end else begin
                        {Hi_out, Lo_out} <= (neg_a ^ neg_b) ? -{hi_acc, lo_acc} : {hi_acc, lo_acc};
                    end
                    HL_W  <= HLW_BOTH;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    HL_W  <= HLW_NONE;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS54 core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and is the sole writer of the Hi/Lo register pair: it drives that register's data inputs and its 2-bit write enable. It sits in the execute stage. The control unit stalls on `busy` and resumes on `done`. Multiply and divide take 33 cycles; MTHI and MTLO take 1 cycle.

## Interface
- `WIDTH`, default 32: operand width. All internal counters are sized as $clog2(WIDTH).
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  operation request; sampled only in IDLE.
- `op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored, with no state change.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTxx source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle completion pulse.
- `Hi_out`  out  WIDTH  data to Hi.
- `Lo_out`  out  WIDTH  data to Lo.
- `HL_W`  out  2  write enable; bit1 = Hi, bit0 = Lo.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - `start` with op 0–3: latch operand magnitudes and sign flags (for signed ops), clear the 64-bit accumulator, set cnt=0, go to RUN.
  - `start` with op 4/5: go directly to DONE.
- RUN: one iteration per cycle, 32 cycles (cnt 0..31). Go to FIX when cnt==31.
  - Multiply: shift-add on magnitudes. The 64-bit product forms in {hi_acc, lo_acc}.
  - Divide: restoring division on magnitudes, 33-bit trial subtract per step. Quotient accumulates in lo_acc, remainder in hi_acc.
- FIX: one cycle of sign correction and special cases.
  - Signed multiply: negate the 64-bit product if sign(a)≠sign(b).
  - Signed divide: negate the quotient if sign(a)≠sign(b); the remainder takes the sign of `a`.
  - Divide by zero (b==0, any signedness): Lo=all ones, Hi=a. This is fixed, not left undefined.
  - 0x80000000 / 0xFFFFFFFF (DIV): Lo=0x80000000, Hi=0. This falls out of the magnitude path with no special case.
- DONE: one cycle, then IDLE.
  - `done`=1.
  - HL_W: 2'b11 for mul/div, 2'b10 for MTHI (Hi_out=a latched), 2'b01 for MTLO (Lo_out=a latched).
- Outputs are registered. Hi_out/Lo_out hold their last values outside DONE, and HL_W=0 outside DONE.
- `start` is ignored in RUN, FIX and DONE. A back-to-back op is accepted in the IDLE cycle after DONE.

## Timing
- Reset values: state=IDLE, busy=0, done=0, HL_W=0, Hi_out=0, Lo_out=0, cnt=0.
- `rst` has priority over `start` and over any state. A reset mid-RUN/FIX aborts the operation with no Hi/Lo write, and all outputs read reset values in the following cycle.
- Latency, for `start` sampled at edge k:
  - Mul/div: RUN at k..k+32, FIX after edge k+32, DONE after edge k+33. `done`, HL_W and results are valid for the whole cycle k+33..k+34.
  - MTxx: DONE after edge k+1.
- `busy`=1 in RUN and FIX; 0 in IDLE and DONE.
- The Hi/Lo register samples on the falling clock edge. HL_W and the data outputs must therefore be glitch-free, register-driven and stable for the full DONE cycle.
- Operands are latched at start; changes on `a`/`b` after acceptance have no effect.

## Structure
- Shared package `mips_pkg`:
  - op encodings (MDU_MULT … MDU_MTLO)
  - FSM state enum
  - HL_W codes HLW_NONE/HLW_LO/HLW_HI/HLW_BOTH
- One sub-module, `mdu_step`: combinational single-iteration datapath (shift-add for multiply, shift-trial-subtract for divide, selected by a mode bit). It is instantiated once.
- The FSM, counter, sign correction and output registers live in `mul_div_unit`.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → 33 cycles after start: done=1, HL_W=11, Hi=0xFFFFFFFE, Lo=0x00000001; busy high in exactly 33 cycles before done.
- MULT a=0xFFFFFFFD(-3) b=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- Signed and unsigned divide:
  - DIV a=0xFFFFFFF9(-7) b=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIVU 7/2 → Lo=3, Hi=1.
- Divide special cases:
  - DIV a=0x1234 b=0 → Lo=0xFFFFFFFF, Hi=0x1234.
  - DIV a=0x80000000 b=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- MTHI a=0xDEADBEEF → next cycle done=1, HL_W=10, Hi_out=0xDEADBEEF. MTLO → HL_W=01. op=6 → no done, busy stays 0.
- Start a DIV and pulse `start` with MULT during RUN → the pulse is ignored and the DIV result is written. Assert `rst` at RUN cycle 10 → next cycle busy=0, HL_W=0, no done. A fresh MULTU 3×5 then yields Lo=15, Hi=0.
